dcache_arbiter: RTL and testbench
=================================

Name: dcache_arbiter

Overview:
- Shares the single request port of the direct-mapped data cache between two requesters (e.g. two traffic generators, or CPU data port plus a debug/fill agent).
- Round-robin arbitration on a valid/ready request channel; an in-order owner-tag FIFO routes each cache response back to the requester that issued it.
- Sits directly between the requesters and the cache's request and response ports, and supports up to MAX_OUT outstanding requests.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_OUT, 4, maximum outstanding accepted-but-unanswered requests; power of two, 2..16.
- CW, 3, width of the outstanding counter; must equal log2(MAX_OUT)+1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rq0_valid  in  1  requester 0 request valid.
- rq0_ready  out  1  requester 0 request accepted this cycle.
- rq0_wr  in  1  requester 0 write (1) / read (0).
- rq0_addr  in  AW  requester 0 address.
- rq0_wdata  in  DW  requester 0 write data.
- rs0_valid  out  1  response for requester 0.
- rs0_rdata  out  DW  read data for requester 0.
- rq1_valid, rq1_ready, rq1_wr, rq1_addr, rq1_wdata: same as requester 0, for requester 1.
- rs1_valid, rs1_rdata: same as requester 0, for requester 1.
- c_valid  out  1  request to cache valid.
- c_ready  in  1  cache accepts request.
- c_wr  out  1  forwarded write flag.
- c_addr  out  AW  forwarded address.
- c_wdata  out  DW  forwarded write data.
- c_rvalid  in  1  cache response valid; one per accepted request, in order; writes also respond.
- c_rdata  in  DW  cache response data.
- outstanding  out  CW  number of requests in flight.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: FIFO empty, outstanding=0, err=0, lock=0, round-robin pointer favours requester 0. All valid/ready outputs are 0 while rst=1.
- Handshake rules:
  - A transfer occurs when valid and ready are both 1 on a rising edge.
  - Requesters hold valid, wr, addr and wdata stable until ready.
- full = (outstanding == MAX_OUT).
- Grant selection, combinational:
  - If lock=1, grant = locked requester.
  - Else, if only one requester is valid, grant that one.
  - Else, if both are valid, grant the requester named by the pointer.
  - Else, no grant.
- Cache request path:
  - c_valid = granted requester's valid & ~full.
  - c_wr, c_addr and c_wdata are muxed from the granted requester. They are 0 when there is no grant.
  - rqN_ready = (grant==N) & c_valid & c_ready. The other requester's ready is 0.
  - Zero-cycle latency, no buffering.
- Lock (registered):
  - Set when c_valid=1 and c_ready=0, holding the grant owner.
  - Cleared on the accept cycle.
  - Guarantees c_* stay stable until the cache accepts.
  - While full, there is no lock and no c_valid. Arbitration re-evaluates when space frees.
- Pointer: on each accept, the pointer moves to the other requester. Pointer is unchanged when only one requester is active, so a lone requester streams back-to-back.
- Owner FIFO:
  - 1 bit wide, MAX_OUT deep, pointers wrap modulo MAX_OUT.
  - Push owner id on accept; pop on c_rvalid.
  - Push and pop in the same cycle: both occur and outstanding is unchanged.
  - Push when full cannot happen, since c_valid is gated by ~full.
  - Pop while full plus a new request in the same cycle: the request stays blocked that cycle (full uses the registered count).
- Response path:
  - On c_rvalid, the head owner selects rsN_valid=1 with rsN_rdata=c_rdata. The other requester's rsM_valid=0.
  - Zero-cycle latency; requesters cannot stall responses.
  - rdata outputs are 0 when not valid.
- Error:
  - c_rvalid while outstanding==0 sets err=1. The response is dropped and neither rs*_valid is asserted.
  - err clears only on rst.
- outstanding is a registered counter: +1 on accept, -1 on pop, never wraps.
- Reset mid-operation: all FIFO contents, lock and pointer are discarded. Responses arriving after reset with outstanding==0 count as errors.

Test Plan:
- Only rq0 valid, 3 reads, c_ready=1, responses 2 cycles later -> 3 consecutive accepts, outstanding peaks at 2 or more, rs0_valid x3 with matching data, rs1_valid never 1.
- Both valid continuously, c_ready=1, immediate responses -> grants alternate 0,1,0,1; each rsN gets its own data in order.
- rq1 granted with c_ready=0 for 4 cycles while rq0 also valid -> c_addr stays rq1_addr, rq0_ready=0, rq1 accepted on the first c_ready=1 cycle, then rq0 is next.
- MAX_OUT=4, no responses, 6 requests offered -> exactly 4 accepted, outstanding=4, c_valid=0; one c_rvalid -> outstanding=3, next request accepted the following cycle.
- c_rvalid with outstanding=0 -> err=1 and stays set; no rs*_valid; rst clears it.
- rst asserted with 2 outstanding -> next cycle outstanding=0, all valid/ready outputs 0, pointer back to requester 0.

Source files
------------

// File: rtl/dcache_arbiter.sv
// Two-requester round-robin arbiter in front of the data cache request port.
// An in-order owner FIFO steers each cache response back to the requester that issued it.
module dcache_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rq0_valid,
  output logic          rq0_ready,
  input  logic          rq0_wr,
  input  logic [AW-1:0] rq0_addr,
  input  logic [DW-1:0] rq0_wdata,
  output logic          rs0_valid,
  output logic [DW-1:0] rs0_rdata,
  input  logic          rq1_valid,
  output logic          rq1_ready,
  input  logic          rq1_wr,
  input  logic [AW-1:0] rq1_addr,
  input  logic [DW-1:0] rq1_wdata,
  output logic          rs1_valid,
  output logic [DW-1:0] rs1_rdata,
  output logic          c_valid,
  input  logic          c_ready,
  output logic          c_wr,
  output logic [AW-1:0] c_addr,
  output logic [DW-1:0] c_wdata,
  input  logic          c_rvalid,
  input  logic [DW-1:0] c_rdata,
  output logic [CW-1:0] outstanding,
  output logic          err
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic [1:0] {ARB_OPEN, ARB_HOLD0, ARB_HOLD1} arb_state_t;

  arb_state_t         state, state_next;
  logic               rr_ptr;
  logic [MAX_OUT-1:0] owner_mem;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               gnt_valid, gnt_id;
  logic               full, accept, pop, head_owner;

  assign full       = (outstanding == CW'(MAX_OUT));
  assign accept     = c_valid & c_ready;
  assign pop        = c_rvalid & (outstanding != '0) & ~rst;
  assign head_owner = owner_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_OPEN;
    else     state <= state_next;
  end

  // A presented-but-refused request pins the grant so c_* cannot change under the cache.
  always_comb begin
    state_next = ARB_OPEN;
    if (c_valid && !c_ready) state_next = gnt_id ? ARB_HOLD1 : ARB_HOLD0;
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (!rst) begin
      unique case (state)
        ARB_HOLD0: gnt_valid = 1'b1;
        ARB_HOLD1: begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b1;
        end
        default: begin
          if (rq0_valid && rq1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = rr_ptr;
          end else if (rq0_valid || rq1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = rq1_valid;
          end
        end
      endcase
    end

    c_valid   = 1'b0;
    c_wr      = 1'b0;
    c_addr    = '0;
    c_wdata   = '0;
    rq0_ready = 1'b0;
    rq1_ready = 1'b0;
    if (gnt_valid) begin
      if (gnt_id) begin
        c_valid   = rq1_valid & ~full;
        c_wr      = rq1_wr;
        c_addr    = rq1_addr;
        c_wdata   = rq1_wdata;
        rq1_ready = c_valid & c_ready;
      end else begin
        c_valid   = rq0_valid & ~full;
        c_wr      = rq0_wr;
        c_addr    = rq0_addr;
        c_wdata   = rq0_wdata;
        rq0_ready = c_valid & c_ready;
      end
    end

    rs0_valid = pop & ~head_owner;
    rs1_valid = pop & head_owner;
    rs0_rdata = rs0_valid ? c_rdata : '0;
    rs1_rdata = rs1_valid ? c_rdata : '0;
  end

  // Pointer only flips on contended accepts so a lone requester can stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (rq0_valid && rq1_valid) rr_ptr <= ~gnt_id;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (c_rvalid && (outstanding == '0)) err <= 1'b1;
      unique case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) owner_mem[wr_ptr] <= gnt_id;
  end

endmodule

// File: tb/tb_dcache_arbiter.sv
// Bench for dcache_arbiter: a vector table, directed multi-cycle sequences and random
// traffic, all checked against a queue-based model of arbitration and response routing.
module tb_dcache_arbiter;

  localparam int MAX_OUT = 4;

  typedef struct packed {
    logic rst; logic v0; logic wr0; logic [31:0] a0; logic [31:0] d0;
    logic v1; logic wr1; logic [31:0] a1; logic [31:0] d1;
    logic crdy; logic crv; logic [31:0] crd;
  } ins_t;

  typedef struct packed {
    logic r0; logic r1; logic s0v; logic [31:0] s0d; logic s1v; logic [31:0] s1d;
    logic cv; logic cwr; logic [31:0] caddr; logic [31:0] cwd; logic [2:0] outst; logic err;
  } outs_t;

  typedef struct { ins_t in; outs_t exp; } vec_t;

  logic clk, rst;
  logic rq0_valid, rq0_ready, rq0_wr, rs0_valid;
  logic rq1_valid, rq1_ready, rq1_wr, rs1_valid;
  logic [31:0] rq0_addr, rq0_wdata, rs0_rdata, rq1_addr, rq1_wdata, rs1_rdata;
  logic c_valid, c_ready, c_wr, c_rvalid, err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [2:0] outstanding;

  dcache_arbiter #(.AW(32), .DW(32), .MAX_OUT(MAX_OUT), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_wr(rq0_wr), .rq0_addr(rq0_addr),
    .rq0_wdata(rq0_wdata), .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_wr(rq1_wr), .rq1_addr(rq1_addr),
    .rq1_wdata(rq1_wdata), .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata),
    .c_valid(c_valid), .c_ready(c_ready), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata), .outstanding(outstanding), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails = 0;
  int mq[$];
  bit mErr;
  int mPtr;
  int mLock;
  int acc0, acc1, rs0n, rs1n;
  int grants[$];
  vec_t vecs[$];

  function automatic ins_t mkIn(bit r, bit v0, bit wr0, logic [31:0] a0, logic [31:0] d0,
                                bit v1, bit wr1, logic [31:0] a1, logic [31:0] d1,
                                bit crdy, bit crv, logic [31:0] crd);
    return {r, v0, wr0, a0, d0, v1, wr1, a1, d1, crdy, crv, crd};
  endfunction

  function automatic outs_t mkOut(bit r0, bit r1, bit s0v, logic [31:0] s0d, bit s1v,
                                  logic [31:0] s1d, bit cv, bit cwr, logic [31:0] caddr,
                                  logic [31:0] cwd, logic [2:0] outst, bit e);
    return {r0, r1, s0v, s0d, s1v, s1d, cv, cwr, caddr, cwd, outst, e};
  endfunction

  function automatic int modelGrant(ins_t s);
    if (s.rst) return -1;
    if (mLock >= 0) return mLock;
    if (s.v0 && s.v1) return mPtr;
    if (s.v0) return 0;
    if (s.v1) return 1;
    return -1;
  endfunction

  function automatic outs_t modelOutputs(ins_t s);
    outs_t o;
    int g;
    bit isFull;
    o = '0;
    o.outst = 3'(mq.size());
    o.err = mErr;
    if (s.rst) return o;
    isFull = (mq.size() == MAX_OUT);
    g = modelGrant(s);
    if (g == 0) begin
      o.cv = s.v0 && !isFull; o.cwr = s.wr0; o.caddr = s.a0; o.cwd = s.d0;
      o.r0 = o.cv && s.crdy;
    end else if (g == 1) begin
      o.cv = s.v1 && !isFull; o.cwr = s.wr1; o.caddr = s.a1; o.cwd = s.d1;
      o.r1 = o.cv && s.crdy;
    end
    if (s.crv && mq.size() > 0) begin
      if (mq[0] == 0) begin o.s0v = 1'b1; o.s0d = s.crd; end
      else begin o.s1v = 1'b1; o.s1d = s.crd; end
    end
    return o;
  endfunction

  task automatic modelReset();
    mq.delete();
    mErr = 1'b0;
    mPtr = 0;
    mLock = -1;
  endtask

  task automatic modelCommit(input ins_t s, input outs_t o);
    int g;
    if (s.rst) begin
      modelReset();
      return;
    end
    g = modelGrant(s);
    if (s.crv) begin
      if (mq.size() == 0) mErr = 1'b1;
      else void'(mq.pop_front());
    end
    if (o.r0 || o.r1) begin
      mq.push_back(g);
      if (s.v0 && s.v1) mPtr = 1 - g;
    end
    mLock = (o.cv && !s.crdy) ? g : -1;
  endtask

  task automatic applyStimulus(input ins_t s);
    rst = s.rst;
    rq0_valid = s.v0; rq0_wr = s.wr0; rq0_addr = s.a0; rq0_wdata = s.d0;
    rq1_valid = s.v1; rq1_wr = s.wr1; rq1_addr = s.a1; rq1_wdata = s.d1;
    c_ready = s.crdy; c_rvalid = s.crv; c_rdata = s.crd;
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = {rq0_ready, rq1_ready, rs0_valid, rs0_rdata, rs1_valid, rs1_rdata,
           c_valid, c_wr, c_addr, c_wdata, outstanding, err};
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic clearLog();
    acc0 = 0; acc1 = 0; rs0n = 0; rs1n = 0;
    grants.delete();
  endtask

  task automatic finishCycle(input ins_t s, input string name);
    outs_t e;
    e = modelOutputs(s);
    checkOutput(name, e);
    if (rq0_ready === 1'b1) begin acc0++; grants.push_back(0); end
    if (rq1_ready === 1'b1) begin acc1++; grants.push_back(1); end
    if (rs0_valid === 1'b1) rs0n++;
    if (rs1_valid === 1'b1) rs1n++;
    @(posedge clk);
    modelCommit(s, e);
    #1;
  endtask

  task automatic cycle(input ins_t s, input string name);
    applyStimulus(s);
    finishCycle(s, name);
  endtask

  task automatic doReset();
    ins_t r;
    r = '0;
    r.rst = 1'b1;
    cycle(r, "reset");
    clearLog();
  endtask

  initial begin
    ins_t s;
    outs_t e;
    bit p0, p1;

    s = '0;
    s.rst = 1'b1;
    applyStimulus(s);
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    clearLog();

    // Hand-derived vectors: contended grant, pointer flip, in-order routing, spurious response.
    vecs.push_back('{mkIn(1,0,0,0,0,0,0,0,0,0,0,0), mkOut(0,0,0,0,0,0,0,0,0,0,0,0)});
    vecs.push_back('{mkIn(0,1,0,'h100,0,0,0,0,0,1,0,0), mkOut(1,0,0,0,0,0,1,0,'h100,0,0,0)});
    vecs.push_back('{mkIn(0,1,0,'h104,0,1,1,'h200,'hAA,1,0,0), mkOut(1,0,0,0,0,0,1,0,'h104,0,1,0)});
    vecs.push_back('{mkIn(0,1,0,'h108,0,1,1,'h200,'hAA,1,0,0), mkOut(0,1,0,0,0,0,1,1,'h200,'hAA,2,0)});
    vecs.push_back('{mkIn(0,1,0,'h108,0,0,0,0,0,1,1,'h11), mkOut(1,0,1,'h11,0,0,1,0,'h108,0,3,0)});
    vecs.push_back('{mkIn(0,0,0,0,0,0,0,0,0,1,1,'h22), mkOut(0,0,1,'h22,0,0,0,0,0,0,3,0)});
    vecs.push_back('{mkIn(0,0,0,0,0,0,0,0,0,1,1,'h33), mkOut(0,0,0,0,1,'h33,0,0,0,0,2,0)});
    vecs.push_back('{mkIn(0,0,0,0,0,0,0,0,0,1,1,'h44), mkOut(0,0,1,'h44,0,0,0,0,0,0,1,0)});
    vecs.push_back('{mkIn(0,0,0,0,0,0,0,0,0,1,1,'h55), mkOut(0,0,0,0,0,0,0,0,0,0,0,0)});
    vecs.push_back('{mkIn(0,0,0,0,0,0,0,0,0,0,0,0), mkOut(0,0,0,0,0,0,0,0,0,0,0,1)});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      finishCycle(vecs[i].in, $sformatf("vec%0d_model", i));
    end

    // Lone requester streams three reads, responses two cycles behind.
    doReset();
    s = '0; s.crdy = 1'b1; s.v0 = 1'b1;
    s.a0 = 32'h1000; cycle(s, "A_req0");
    s.a0 = 32'h1004; cycle(s, "A_req1");
    checkValue("A_outstanding_peak", 32'(outstanding), 2);
    s.a0 = 32'h1008; s.crv = 1'b1; s.crd = 32'hA0; cycle(s, "A_req2");
    s.v0 = 1'b0; s.crd = 32'hA1; cycle(s, "A_rsp1");
    s.crd = 32'hA2; cycle(s, "A_rsp2");
    s.crv = 1'b0; cycle(s, "A_idle");
    checkValue("A_accepts", 32'(acc0), 3);
    checkValue("A_rs0_count", 32'(rs0n), 3);
    checkValue("A_rs1_count", 32'(rs1n), 0);

    // Both requesters always valid: grants alternate, responses come back immediately.
    doReset();
    for (int i = 0; i < 4; i++) begin
      s = '0; s.crdy = 1'b1; s.v0 = 1'b1; s.v1 = 1'b1;
      s.a0 = 32'h2000 + 32'(4 * acc0); s.a1 = 32'h3000 + 32'(4 * acc1); s.wr1 = 1'b1;
      s.d1 = 32'hC0 + 32'(acc1);
      s.crv = (i > 0); s.crd = 32'hB0 + 32'(i);
      cycle(s, "B_alt");
    end
    s = '0; s.crv = 1'b1; s.crd = 32'hB4; cycle(s, "B_last_rsp");
    checkValue("B_grant_order", {28'd0, 4'(grants[0]), 4'(0)} >> 4 |
               32'({grants[0][0], grants[1][0], grants[2][0], grants[3][0]}), 32'b0101);
    checkValue("B_rs0_count", 32'(rs0n), 2);
    checkValue("B_rs1_count", 32'(rs1n), 2);

    // Refused request from rq1 holds the grant until the cache accepts it.
    doReset();
    s = '0; s.crdy = 1'b1; s.v0 = 1'b1; s.v1 = 1'b1; s.a0 = 32'h4000; s.a1 = 32'h5000;
    cycle(s, "C_first");
    s.a0 = 32'h4004; s.crdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(s);
      checkValue("C_hold_addr", c_addr, 32'h5000);
      checkValue("C_rq0_blocked", 32'(rq0_ready), 0);
      finishCycle(s, "C_stall");
    end
    s.crdy = 1'b1; cycle(s, "C_release");
    s.a1 = 32'h5004; cycle(s, "C_next");
    checkValue("C_grant_order", 32'({grants[0][0], grants[1][0], grants[2][0]}), 32'b010);

    // Fill to MAX_OUT with no responses; a pop frees space only from the next cycle.
    doReset();
    s = '0; s.crdy = 1'b1; s.v0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s.a0 = 32'h6000 + 32'(4 * acc0);
      cycle(s, "D_fill");
    end
    checkValue("D_accepts", 32'(acc0), 4);
    checkValue("D_outstanding_full", 32'(outstanding), 4);
    checkValue("D_cvalid_full", 32'(c_valid), 0);
    s.crv = 1'b1; s.crd = 32'hD0;
    applyStimulus(s);
    checkValue("D_blocked_on_pop", 32'(rq0_ready), 0);
    finishCycle(s, "D_pop");
    checkValue("D_outstanding_after_pop", 32'(outstanding), 3);
    s.crv = 1'b0; cycle(s, "D_refill");
    checkValue("D_accept_after_free", 32'(acc0), 5);

    // Response with nothing in flight is dropped and raises a sticky error.
    doReset();
    s = '0; s.crv = 1'b1; s.crd = 32'hE0; cycle(s, "E_spurious");
    checkValue("E_no_response", 32'(rs0n + rs1n), 0);
    s = '0; cycle(s, "E_idle0"); cycle(s, "E_idle1");
    checkValue("E_err_sticky", 32'(err), 1);
    doReset();
    checkValue("E_err_cleared", 32'(err), 0);

    // Reset with two requests in flight and the pointer favouring rq1.
    doReset();
    s = '0; s.crdy = 1'b1; s.v0 = 1'b1; s.v1 = 1'b1; s.a0 = 32'h7000; s.a1 = 32'h8000;
    cycle(s, "F_acc0");
    s.v0 = 1'b0; cycle(s, "F_acc1");
    checkValue("F_outstanding_two", 32'(outstanding), 2);
    s.rst = 1'b1; s.v0 = 1'b1;
    applyStimulus(s);
    checkValue("F_rst_cvalid", 32'(c_valid), 0);
    checkValue("F_rst_ready", 32'(rq0_ready | rq1_ready), 0);
    finishCycle(s, "F_rst");
    checkValue("F_outstanding_cleared", 32'(outstanding), 0);
    clearLog();
    s.rst = 1'b0; s.a0 = 32'h7004; s.a1 = 32'h8004; cycle(s, "F_after");
    checkValue("F_pointer_reset", 32'(grants.size() == 1 && grants[0] == 0), 1);

    // Random traffic obeying the requester hold rule and the cache's in-order response rule.
    doReset();
    p0 = 1'b0; p1 = 1'b0; s = '0;
    for (int i = 0; i < 600; i++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin
        p0 = 1'b1; s.wr0 = 1'($urandom); s.a0 = $urandom; s.d0 = $urandom;
      end
      if (!p1 && $urandom_range(1, 0) == 1) begin
        p1 = 1'b1; s.wr1 = 1'($urandom); s.a1 = $urandom; s.d1 = $urandom;
      end
      s.v0 = p0; s.v1 = p1;
      s.crdy = ($urandom_range(9, 0) < 7);
      s.crv = (mq.size() > 0) && ($urandom_range(9, 0) < 4);
      s.crd = $urandom;
      e = modelOutputs(s);
      cycle(s, "rand");
      if (e.r0) p0 = 1'b0;
      if (e.r1) p1 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
